// File: rtl/acc_pkg.sv
// Shared defaults and FSM state type for the accumulator frame sampler.
package acc_pkg;

    localparam int unsigned ACC_W_DEF      = 15;
    localparam int unsigned FRAME_LEN_DEF  = 10;
    localparam int unsigned FIFO_DEPTH_DEF = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/acc_sum_fifo.sv
// Synchronous result FIFO: push side is fire-and-forget, pop side is valid/ready.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module acc_sum_fifo #(
    parameter int unsigned W     = 15,
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_ready,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic         w_full;
    logic         w_empty;
    logic         w_pop;
    logic         w_push;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = !w_empty && i_ready;
    assign w_push  = i_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= i_data;
                r_wr_ptr                <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule

// File: rtl/acc_frame_sampler.sv
// Samples a free-running accumulator every FRAME_LEN cycles and buffers the
// per-frame difference (modular) for a valid/ready consumer.
module acc_frame_sampler
    import acc_pkg::*;
#(
    parameter int unsigned ACC_W      = ACC_W_DEF,
    parameter int unsigned FRAME_LEN  = FRAME_LEN_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ACC_W-1:0] acc_in,
    input  logic             start,
    input  logic             stop,
    input  logic             clr_ovr,
    output logic [ACC_W-1:0] sum_out,
    output logic             sum_valid,
    input  logic             sum_ready,
    output logic             busy,
    output logic             overrun
);

    localparam int unsigned CNT_W = $clog2(FRAME_LEN + 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [ACC_W-1:0]   r_base;
    logic               r_overrun;
    logic               w_boundary;
    logic               w_drop;
    logic               w_full;
    logic               w_empty;
    logic [ACC_W-1:0]   w_diff;
    logic [ACC_W-1:0]   w_head;

    // Modular subtraction keeps the frame sum exact across upstream wrap.
    assign w_diff = acc_in - r_base;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_boundary   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                w_boundary = (r_cnt == CNT_W'(FRAME_LEN));
                if (stop) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // A boundary result is lost only if the buffer stays full this cycle.
    assign w_drop = w_boundary && w_full && !(!w_empty && sum_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_base    <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (r_state == ST_IDLE) begin
                if (start) begin
                    r_base <= acc_in;
                    r_cnt  <= CNT_W'(1);
                end
            end else if (stop) begin
                r_cnt <= '0;
            end else if (w_boundary) begin
                r_base <= acc_in;
                r_cnt  <= CNT_W'(1);
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (clr_ovr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    acc_sum_fifo #(
        .W     (ACC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_boundary),
        .i_data  (w_diff),
        .i_ready (sum_ready),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign sum_out   = w_head;
    assign sum_valid = !w_empty;
    assign busy      = (r_state == ST_RUN);
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_acc_frame_sampler.sv
// Bench for acc_frame_sampler: table vectors, directed corner sequences and
// random stimulus against a queue-based frame model.
module tb_acc_frame_sampler;

    localparam int ACC_W      = 15;
    localparam int FRAME_LEN  = 10;
    localparam int FIFO_DEPTH = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [ACC_W-1:0] acc_in;
    logic             start;
    logic             stop;
    logic             clr_ovr;
    logic [ACC_W-1:0] sum_out;
    logic             sum_valid;
    logic             sum_ready;
    logic             busy;
    logic             overrun;

    acc_frame_sampler #(
        .ACC_W      (ACC_W),
        .FRAME_LEN  (FRAME_LEN),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .acc_in    (acc_in),
        .start     (start),
        .stop      (stop),
        .clr_ovr   (clr_ovr),
        .sum_out   (sum_out),
        .sum_valid (sum_valid),
        .sum_ready (sum_ready),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: frame position, frame base value, result queue, sticky flag.
    bit               m_run;
    int               m_phase;
    logic [ACC_W-1:0] m_base;
    logic [ACC_W-1:0] mq[$];
    bit               m_ovr;
    logic [ACC_W-1:0] m_inc;

    typedef struct {
        logic [ACC_W-1:0] a0;
        logic [ACC_W-1:0] inc;
        logic [ACC_W-1:0] exp_sum;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock: advance the model with the current inputs, then compare.
    task automatic tick();
        bit               pop;
        bit               drop;
        logic [ACC_W-1:0] res;
        pop  = (mq.size() != 0) && sum_ready;
        drop = 1'b0;
        if (rst) begin
            m_run = 0; m_phase = 0; m_base = '0; m_ovr = 0;
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (!m_run) begin
                if (start) begin
                    m_run = 1; m_phase = 1; m_base = acc_in;
                end
            end else if (m_phase == FRAME_LEN) begin
                res = acc_in - m_base;
                if (mq.size() < FIFO_DEPTH) mq.push_back(res);
                else drop = 1'b1;
                m_base  = acc_in;
                m_phase = 1;
                if (stop) m_run = 0;
            end else if (stop) begin
                m_run = 0;
            end else begin
                m_phase++;
            end
            if (drop) m_ovr = 1;
            else if (clr_ovr) m_ovr = 0;
        end
        @(posedge clk);
        #1;
        chk("busy", 32'(busy), 32'(m_run));
        chk("sum_valid", 32'(sum_valid), 32'(mq.size() != 0));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        if (mq.size() != 0) chk("sum_out", 32'(sum_out), 32'(mq[0]));
        acc_in = acc_in + m_inc;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 0; stop = 0; clr_ovr = 0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        vecs[0] = '{a0: 15'd0,     inc: 15'd10,   exp_sum: 15'd100};
        vecs[1] = '{a0: 15'd32760, inc: 15'd10,   exp_sum: 15'd100};
        vecs[2] = '{a0: 15'd32767, inc: 15'd1,    exp_sum: 15'd10};
        vecs[3] = '{a0: 15'd100,   inc: 15'd3277, exp_sum: 15'd2};
        vecs[4] = '{a0: 15'd5,     inc: 15'd0,    exp_sum: 15'd0};

        acc_in = '0; m_inc = '0; sum_ready = 1'b0;
        start = 0; stop = 0; clr_ovr = 0; rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("reset sum_out", 32'(sum_out), 32'd0);
        chk("reset sum_valid", 32'(sum_valid), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset overrun", 32'(overrun), 32'd0);

        // Single-frame vectors: result valid exactly 11 cycles after start.
        foreach (vecs[v]) begin
            do_reset();
            sum_ready = 1'b1;
            acc_in = vecs[v].a0; m_inc = vecs[v].inc;
            start = 1'b1; tick(); start = 1'b0;
            for (int j = 1; j <= FRAME_LEN; j++) begin
                tick();
                chk($sformatf("vec%0d valid j%0d", v, j), 32'(sum_valid), 32'(j == FRAME_LEN));
            end
            chk($sformatf("vec%0d sum", v), 32'(sum_out), 32'(vecs[v].exp_sum));
            stop = 1'b1; tick(); stop = 1'b0;
        end

        // Back-to-back frames arrive every FRAME_LEN cycles.
        do_reset();
        sum_ready = 1'b1; acc_in = '0; m_inc = 15'd10;
        start = 1'b1; tick(); start = 1'b0;
        for (int j = 1; j <= 3 * FRAME_LEN; j++) begin
            tick();
            if (j % FRAME_LEN == 0) chk("periodic sum", 32'(sum_out), 32'd100);
        end
        stop = 1'b1; tick(); stop = 1'b0;

        // Consumer stalled for three frames: third result dropped, first two held.
        do_reset();
        sum_ready = 1'b0; acc_in = '0; m_inc = 15'd10;
        for (int j = 0; j <= 3 * FRAME_LEN; j++) begin
            start = (j == 0);
            tick();
        end
        start = 1'b0;
        chk("ovr set", 32'(overrun), 32'd1);
        chk("ovr head", 32'(sum_out), 32'd100);
        stop = 1'b1; clr_ovr = 1'b1; tick(); stop = 1'b0; clr_ovr = 1'b0;
        chk("ovr cleared", 32'(overrun), 32'd0);
        chk("stop keeps buffer", 32'(sum_valid), 32'd1);
        sum_ready = 1'b1; tick(); tick();
        chk("drained", 32'(sum_valid), 32'd0);

        // Stop mid-frame discards; stop on boundary pushes then idles.
        do_reset();
        sum_ready = 1'b0; acc_in = '0; m_inc = 15'd10;
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick(); tick();
        stop = 1'b1; tick(); stop = 1'b0;
        chk("stop cnt4 busy", 32'(busy), 32'd0);
        chk("stop cnt4 valid", 32'(sum_valid), 32'd0);
        start = 1'b1; tick(); start = 1'b0;
        for (int j = 1; j < FRAME_LEN; j++) tick();
        stop = 1'b1; tick(); stop = 1'b0;
        chk("stop cnt10 busy", 32'(busy), 32'd0);
        chk("stop cnt10 sum", 32'(sum_out), 32'd100);
        tick();
        chk("stop cnt10 idle", 32'(busy), 32'd0);

        // Full buffer with a pop on the boundary accepts the new result in order.
        do_reset();
        sum_ready = 1'b0; acc_in = '0;
        for (int j = 0; j <= 3 * FRAME_LEN; j++) begin
            m_inc     = (j < 10) ? 15'd10 : (j < 20) ? 15'd7 : 15'd3;
            start     = (j == 0);
            sum_ready = (j == 3 * FRAME_LEN);
            stop      = (j == 3 * FRAME_LEN);
            tick();
        end
        start = 1'b0; stop = 1'b0; sum_ready = 1'b1;
        chk("full+pop ovr", 32'(overrun), 32'd0);
        chk("full+pop head", 32'(sum_out), 32'd70);
        tick();
        chk("full+pop next", 32'(sum_out), 32'd30);
        tick();
        chk("full+pop empty", 32'(sum_valid), 32'd0);

        // Reset mid-frame drops buffered results; a restart still sums correctly.
        do_reset();
        sum_ready = 1'b0; acc_in = 15'd1234; m_inc = 15'd10;
        start = 1'b1; tick(); start = 1'b0;
        for (int j = 1; j <= FRAME_LEN + 3; j++) tick();
        chk("pre-rst valid", 32'(sum_valid), 32'd1);
        rst = 1'b1; start = 1'b1; stop = 1'b1; clr_ovr = 1'b1; tick();
        rst = 1'b0; start = 1'b0; stop = 1'b0; clr_ovr = 1'b0;
        chk("rst valid", 32'(sum_valid), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst sum_out", 32'(sum_out), 32'd0);
        sum_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        for (int j = 1; j <= FRAME_LEN; j++) tick();
        chk("restart sum", 32'(sum_out), 32'd100);

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            m_inc     = ACC_W'($urandom_range(0, 6000));
            start     = ($urandom_range(0, 7) == 0);
            stop      = ($urandom_range(0, 39) == 0);
            sum_ready = ($urandom_range(0, 2) != 0);
            clr_ovr   = ($urandom_range(0, 29) == 0);
            rst       = ($urandom_range(0, 599) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
